// File: rtl/moving_avg_pkg.sv
// Shared types and width helpers for the multi-channel moving-average filter.
package moving_avg_pkg;

    typedef enum logic {
        RND_TRUNC   = 1'b0,
        RND_HALF_UP = 1'b1
    } rnd_mode_e;

    function automatic int sum_width(input int dw, input int log2_n);
        return dw + log2_n;
    endfunction

    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/mavg_ring.sv
// One channel's sample window: ring buffer, write pointer and saturating fill count.
module mavg_ring #(
    parameter int DW     = 16,
    parameter int LOG2_N = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DW-1:0]     wr_data,
    output logic [DW-1:0]     oldest,
    output logic [LOG2_N:0]   fill
);

    localparam int N = 1 << LOG2_N;

    logic [DW-1:0]     mem_q [N];
    logic [LOG2_N-1:0] wptr_q;
    logic [LOG2_N:0]   fill_q;

    // The slot about to be overwritten holds the sample leaving the window.
    assign oldest = mem_q[wptr_q];
    assign fill   = fill_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            fill_q <= '0;
        end else if (wr_en) begin
            mem_q[wptr_q] <= wr_data;
            wptr_q        <= wptr_q + 1'b1;
            if (fill_q != (LOG2_N+1)'(N)) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/moving_avg_mc.sv
// Multi-channel moving-average filter; channels share one adder/shifter and a registered output.
module moving_avg_mc
    import moving_avg_pkg::*;
#(
    parameter int DW     = 16,
    parameter int LOG2_N = 2,
    parameter int CH     = 4,
    parameter int RND    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ch_width(CH)-1:0] in_ch,
    input  logic [DW-1:0]           in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ch_width(CH)-1:0] out_ch,
    output logic [DW-1:0]           out_data,
    output logic                    out_full
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = sum_width(DW, LOG2_N);
    localparam int CW = ch_width(CH);
    localparam rnd_mode_e RMODE = (RND != 0) ? RND_HALF_UP : RND_TRUNC;
    localparam logic [SW:0] RND_ADD = (RMODE == RND_HALF_UP) ? (SW+1)'(N / 2) : '0;

    logic [DW-1:0]   oldest_arr [CH];
    logic [LOG2_N:0] fill_arr   [CH];
    logic [SW-1:0]   sum_q      [CH];

    logic            accept;
    logic            ch_ok;
    logic            hit;
    logic [DW-1:0]   oldest_sel;
    logic [LOG2_N:0] fill_sel;
    logic [SW-1:0]   sum_sel;
    logic [SW-1:0]   sum_new;
    logic [SW:0]     rnd_sum;
    logic [DW-1:0]   avg;
    logic            full_next;

    assign in_ready = rst_n && !clr && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign ch_ok    = int'(in_ch) < CH;
    assign hit      = accept && ch_ok;

    always_comb begin
        oldest_sel = '0;
        fill_sel   = '0;
        sum_sel    = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (in_ch == CW'(i)) begin
                oldest_sel = oldest_arr[i];
                fill_sel   = fill_arr[i];
                sum_sel    = sum_q[i];
            end
        end
    end

    // Intermediate may wrap modulo 2^SW; the final sum is always non-negative and in range.
    assign sum_new   = sum_sel + SW'(in_data) - SW'(oldest_sel);
    assign rnd_sum   = {1'b0, sum_new} + RND_ADD;
    assign avg       = DW'(rnd_sum >> LOG2_N);
    assign full_next = ({1'b0, fill_sel} + 1'b1) >= (LOG2_N+2)'(N);

    for (genvar g = 0; g < CH; g++) begin : g_ring
        mavg_ring #(
            .DW     (DW),
            .LOG2_N (LOG2_N)
        ) u_ring (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .wr_en   (hit && (in_ch == CW'(g))),
            .wr_data (in_data),
            .oldest  (oldest_arr[g]),
            .fill    (fill_arr[g])
        );
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < CH; i++) begin
            if (!rst_n || clr) begin
                sum_q[i] <= '0;
            end else if (hit && (in_ch == CW'(i))) begin
                sum_q[i] <= sum_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_full  <= 1'b0;
        end else if (hit) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_data  <= avg;
            out_full  <= full_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_avg_mc.sv
// Self-checking bench for moving_avg_mc: directed scenarios plus randomized traffic vs a window model.
module tb_moving_avg_mc;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ch = '0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_ch;
    logic [15:0] out_data;
    logic        out_full;

    logic        r_clr = 1'b0;
    logic        r_in_valid = 1'b0;
    logic        r_in_ready;
    logic [0:0]  r_in_ch = '0;
    logic [15:0] r_in_data = '0;
    logic        r_out_valid;
    logic        r_out_ready = 1'b1;
    logic [0:0]  r_out_ch;
    logic [15:0] r_out_data;
    logic        r_out_full;

    int passed = 0;
    int total  = 0;

    // Model: the last N accepted samples per channel (queue 3 belongs to the rounding DUT).
    int hist [4][$];

    always #5 clk = ~clk;

    moving_avg_mc #(.DW(16), .LOG2_N(2), .CH(3), .RND(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .out_data(out_data), .out_full(out_full)
    );

    moving_avg_mc #(.DW(16), .LOG2_N(2), .CH(1), .RND(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .clr(r_clr),
        .in_valid(r_in_valid), .in_ready(r_in_ready), .in_ch(r_in_ch), .in_data(r_in_data),
        .out_valid(r_out_valid), .out_ready(r_out_ready), .out_ch(r_out_ch),
        .out_data(r_out_data), .out_full(r_out_full)
    );

    function automatic void model_push(input int q, input int d, input int rnd,
                                       output int avg, output bit full);
        int s;
        hist[q].push_back(d);
        if (hist[q].size() > N) void'(hist[q].pop_front());
        s = 0;
        for (int k = 0; k < hist[q].size(); k++) s += hist[q][k];
        avg  = (s + (rnd != 0 ? N / 2 : 0)) / N;
        full = (hist[q].size() == N);
    endfunction

    task automatic push(input int c, input int d);
        in_valid = 1'b1;
        in_ch    = 2'(c);
        in_data  = 16'(d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic rpush(input int d);
        r_in_valid = 1'b1;
        r_in_data  = 16'(d);
        @(posedge clk); #1;
        r_in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        r_clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        r_clr = 1'b0;
        for (int q = 0; q < 4; q++) hist[q].delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({in_ready, out_valid, out_ch, out_data, out_full} !== 21'd0) begin
            $display("FAIL reset_state: got rdy=%0b v=%0b ch=%0d data=%0d full=%0b, want all 0",
                     in_ready, out_valid, out_ch, out_data, out_full);
        end else passed++;
        total++;
        if ({r_in_ready, r_out_valid, r_out_data} !== 18'd0) begin
            $display("FAIL reset_state_r: got rdy=%0b v=%0b data=%0d, want 0", r_in_ready, r_out_valid, r_out_data);
        end else passed++;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %0b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_basic();
        int  d  [5] = '{4, 8, 12, 16, 20};
        int  ea [5] = '{1, 3, 6, 10, 14};
        bit  ef [5] = '{0, 0, 0, 1, 1};
        do_clr();
        for (int i = 0; i < 5; i++) begin
            push(0, d[i]);
            total++;
            if ({out_valid, out_ch, out_data, out_full} !== {1'b1, 2'd0, 16'(ea[i]), ef[i]}) begin
                $display("FAIL basic[%0d]: got v=%0b ch=%0d data=%0d full=%0b, want v=1 ch=0 data=%0d full=%0b",
                         i, out_valid, out_ch, out_data, out_full, ea[i], ef[i]);
            end else passed++;
        end
    endtask

    task automatic test_interleave();
        int c  [4] = '{0, 1, 0, 1};
        int d  [4] = '{4, 100, 8, 200};
        int ea [4] = '{1, 25, 3, 75};
        do_clr();
        for (int i = 0; i < 4; i++) begin
            push(c[i], d[i]);
            total++;
            if ({out_valid, out_ch, out_data, out_full} !== {1'b1, 2'(c[i]), 16'(ea[i]), 1'b0}) begin
                $display("FAIL interleave[%0d]: got v=%0b ch=%0d data=%0d full=%0b, want ch=%0d data=%0d full=0",
                         i, out_valid, out_ch, out_data, out_full, c[i], ea[i]);
            end else passed++;
        end
    endtask

    task automatic test_clear();
        do_clr();
        push(0, 4);
        push(0, 8);
        push(0, 12);
        clr = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) $display("FAIL clr_ready: got %0b want 0", in_ready);
        else passed++;
        @(posedge clk); #1;
        clr = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL clr_out_valid: got %0b want 0", out_valid);
        else passed++;
        push(0, 16);
        total++;
        if ({out_valid, out_data, out_full} !== {1'b1, 16'd4, 1'b0}) begin
            $display("FAIL clr_first_sample: got v=%0b data=%0d full=%0b, want v=1 data=4 full=0",
                     out_valid, out_data, out_full);
        end else passed++;
        do_clr();
        clr = 1'b1;
        in_valid = 1'b1;
        in_ch = 2'd0;
        in_data = 16'd200;
        @(posedge clk); #1;
        clr = 1'b0;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0) $display("FAIL clr_with_valid_out: got v=%0b want 0", out_valid);
        else passed++;
        push(0, 40);
        total++;
        if (out_data !== 16'd10) $display("FAIL clr_with_valid_lost: got data=%0d want 10", out_data);
        else passed++;
    endtask

    task automatic test_oob();
        do_clr();
        push(0, 20);
        push(3, 1000);
        total++;
        if (out_valid !== 1'b0) $display("FAIL oob_no_output: got v=%0b want 0", out_valid);
        else passed++;
        push(0, 20);
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd0, 16'd10}) begin
            $display("FAIL oob_state_ch0: got v=%0b ch=%0d data=%0d, want v=1 ch=0 data=10",
                     out_valid, out_ch, out_data);
        end else passed++;
        push(2, 8);
        total++;
        if ({out_ch, out_data} !== {2'd2, 16'd2}) begin
            $display("FAIL oob_state_ch2: got ch=%0d data=%0d, want ch=2 data=2", out_ch, out_data);
        end else passed++;
    endtask

    task automatic test_backpressure();
        do_clr();
        out_ready = 1'b0;
        push(1, 40);
        in_valid = 1'b1;
        in_ch = 2'd2;
        in_data = 16'd80;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({in_ready, out_valid, out_ch, out_data} !== {1'b0, 1'b1, 2'd1, 16'd10}) begin
                $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b ch=%0d data=%0d, want rdy=0 v=1 ch=1 data=10",
                         i, in_ready, out_valid, out_ch, out_data);
            end else passed++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", in_ready);
        else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++;
        if ({out_valid, out_ch, out_data} !== {1'b1, 2'd2, 16'd20}) begin
            $display("FAIL bp_release_out: got v=%0b ch=%0d data=%0d, want v=1 ch=2 data=20",
                     out_valid, out_ch, out_data);
        end else passed++;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got v=%0b want 0", out_valid);
        else passed++;
        push(2, 80);
        total++;
        if (out_data !== 16'd40) $display("FAIL bp_single_accept: got data=%0d want 40", out_data);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_clr();
        push(0, 100);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int q = 0; q < 4; q++) hist[q].delete();
        total++;
        if ({out_valid, out_data} !== 17'd0) begin
            $display("FAIL reset_mid: got v=%0b data=%0d, want v=0 data=0", out_valid, out_data);
        end else passed++;
        push(0, 8);
        total++;
        if ({out_valid, out_data, out_full} !== {1'b1, 16'd2, 1'b0}) begin
            $display("FAIL reset_mid_first: got v=%0b data=%0d full=%0b, want v=1 data=2 full=0",
                     out_valid, out_data, out_full);
        end else passed++;
    endtask

    task automatic test_round();
        int avg;
        bit full;
        do_clr();
        rpush(6);
        total++;
        if ({r_out_valid, r_out_data} !== {1'b1, 16'd2}) begin
            $display("FAIL round_six: got v=%0b data=%0d, want v=1 data=2", r_out_valid, r_out_data);
        end else passed++;
        do_clr();
        for (int i = 0; i < 4; i++) begin
            rpush(65535);
            model_push(3, 65535, 1, avg, full);
            total++;
            if ({r_out_valid, r_out_ch, r_out_data, r_out_full} !== {1'b1, 1'b0, 16'(avg), full}) begin
                $display("FAIL round_max[%0d]: got v=%0b data=%0d full=%0b, want data=%0d full=%0b",
                         i, r_out_valid, r_out_data, r_out_full, avg, full);
            end else passed++;
        end
        total++;
        if (r_out_data !== 16'hFFFF) $display("FAIL round_max_final: got %0h want ffff", r_out_data);
        else passed++;
    endtask

    task automatic test_random();
        int  c, d, avg;
        bit  full;
        do_clr();
        for (int i = 0; i < 300; i++) begin
            c = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 65535));
            push(c, d);
            total++;
            if (c < 3) begin
                model_push(c, d, 0, avg, full);
                if ({out_valid, out_ch, out_data, out_full} !== {1'b1, 2'(c), 16'(avg), full}) begin
                    $display("FAIL random[%0d]: got v=%0b ch=%0d data=%0d full=%0b, want ch=%0d data=%0d full=%0b",
                             i, out_valid, out_ch, out_data, out_full, c, avg, full);
                end else passed++;
            end else begin
                if (out_valid !== 1'b0) $display("FAIL random_oob[%0d]: got v=%0b want 0", i, out_valid);
                else passed++;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                total++;
                if (out_valid !== 1'b0) $display("FAIL random_idle[%0d]: got v=%0b want 0", i, out_valid);
                else passed++;
            end
        end
        for (int i = 0; i < 50; i++) begin
            d = int'($urandom_range(0, 65535));
            rpush(d);
            model_push(3, d, 1, avg, full);
            total++;
            if ({r_out_valid, r_out_data, r_out_full} !== {1'b1, 16'(avg), full}) begin
                $display("FAIL random_round[%0d]: got v=%0b data=%0d full=%0b, want data=%0d full=%0b",
                         i, r_out_valid, r_out_data, r_out_full, avg, full);
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_interleave();
        test_clear();
        test_oob();
        test_backpressure();
        test_reset_mid();
        test_round();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/moving_avg_mc.md
# moving_avg_mc

Multi-channel, parametrised moving-average filter: per-channel sliding window of 2^LOG2_N samples, configurable data width and channel count, valid/ready handshakes on both sides, selectable rounding, and a synchronous flush. Time-multiplexed channels share one adder/shifter datapath. The block sits between sample sources (ADC/sensor front-ends) and downstream consumers and is the general successor of the single-channel 4-tap averager.

## Interface
- DW, 16: sample width, unsigned
- LOG2_N, 2: log2 of window depth N; legal 1..6
- CH, 4: channel count; legal 1..16
- RND, 0: 0 = truncate, 1 = round half up
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- clr  in  1  synchronous flush of all channel state
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept
- in_ch  in  max(1,$clog2(CH))  channel of input sample
- in_data  in  DW  sample
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_ch  out  max(1,$clog2(CH))  channel of result
- out_data  out  DW  window average
- out_full  out  1  channel window completely filled when result produced

## Operation
- Per channel: ring buffer of N entries × DW, write pointer (LOG2_N bits, wraps N-1→0), fill counter saturating at N, running sum of DW+LOG2_N bits.
- Accept = in_valid && in_ready. On accept for channel c: oldest = buf[c][wptr[c]]; sum_new = sum[c] + in_data - oldest; buf[c][wptr[c]] ← in_data; wptr[c]++; sum[c] ← sum_new; fill[c] ← min(fill[c]+1, N).
- Result: out_data = (sum_new + (RND ? N/2 : 0)) >> LOG2_N. Rounding add uses DW+LOG2_N+1 bits; result never exceeds 2^DW-1 (no saturation logic needed).
- Before window is full, empty slots count as zero (average over N, not over fill). out_full = (fill[c]+1 >= N) at accept.
- Out-of-range in_ch (≥ CH) on accept: sample dropped, no state change, no output.
- clr: all buffers, sums, pointers, fill counters, out_valid cleared next edge; in_ready = 0 while clr high; clr has priority over a simultaneous accept (sample lost).
- Channels independent; interleaving in any order permitted, including same channel back-to-back.

## Timing
- Reset values: in_ready 0 during reset, out_valid 0, out_data 0, out_ch 0, out_full 0; all internal state zero.
- Latency: result registered; appears with out_valid one cycle after accept.
- in_ready = !clr && (!out_valid || out_ready). Full throughput of one sample/cycle with out_ready held high.
- Output stable (out_data, out_ch, out_full) while out_valid && !out_ready.
- Back-to-back same-channel samples: second uses sum updated by first (no hazard; state written on the accepting edge).
- Reset or clr mid-stream: pending result discarded; first post-flush sample averages as if window empty.

## Structure
- Package moving_avg_pkg: rounding-mode enum (RND_TRUNC, RND_HALF_UP), sum-width function DW+LOG2_N, channel-index width function.
- Sub-module mavg_ring: one channel’s ring buffer + write pointer + fill counter, with read-oldest/write-new port and clear; instantiated CH times via generate. Top holds shared sum array, arithmetic, and output register.

## Test plan
- DW=16, LOG2_N=2, CH=1, RND=0, out_ready=1: feed 4,8,12,16,20 → out_data 1,3,6,10,14; out_full 0,0,0,1,1.
- RND=1, single sample 6 → out_data 2 (truncate build: 1); sample 0xFFFF ×4 → 0xFFFF on 4th, no overflow.
- CH=2 interleaved: ch0 4,8 / ch1 100,200 alternating → ch0 1,3; ch1 25,75; out_ch matches each input.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready 0, out_data/out_ch held; release → next sample accepted one cycle later, no loss or duplication.
- clr after ch0 got 4,8,12 → next ch0 sample 16 gives 4, out_full 0; clr and in_valid same cycle → sample not accepted.
- rst_n low mid-stream with out_valid=1 → next edge out_valid 0, out_data 0; in_ch=CH on accept → no output, state unchanged.
